sot_frame_aligner_v2: RTL and testbench
=======================================

Name: sot_frame_aligner_v2

Overview:
Parametrised successor of the per-VFAT S-bit frame aligner. It decodes the one-hot start-of-frame (SoT) word and derives the bitslip. A lock FSM with hunt, verify and locked states tolerates transient SoT glitches while locked. Sticky status and saturating error/relock counters feed the trigger-link monitoring registers.

Parameters:
FRAME_SIZE, 8, bits per frame per chunk; legal values 4, 8, 16.
NUM_CHUNKS, 8, frame-sized chunks per VFAT; S-bit width MXSBITS = FRAME_SIZE*NUM_CHUNKS.
SLIP_OFFSET, 1, added to the decoded SoT index to form the bitslip, mod FRAME_SIZE.
CNT_W, 12, width of the stability counter and threshold.
ERR_W, 16, width of the error and relock counters.

Ports:
clock  in  1  40 MHz frame clock.
reset_n_i  in  1  asynchronous active-low reset.
sbits_i  in  MXSBITS  deserialised S-bits; chunk c is bits [FRAME_SIZE*(c+1)-1 : FRAME_SIZE*c].
start_of_frame_i  in  FRAME_SIZE  deserialised SoT bits.
mask_i  in  1  channel masked.
clear_i  in  1  one-cycle pulse that clears sticky status and counters.
aligned_count_to_ready_i  in  CNT_W  consecutive good frames required to lock.
miss_tolerance_i  in  4  consecutive bad frames tolerated while locked.
sbits_o  out  MXSBITS  frame-aligned S-bits.
bitslip_cnt_o  out  clog2(FRAME_SIZE)  applied slip.
sot_is_aligned_o  out  1  high in LOCKED.
sot_unstable_o  out  1  sticky; lock was lost.
sot_err_cnt_o  out  ERR_W  saturating count of bad frames seen while LOCKED.
sot_relock_cnt_o  out  ERR_W  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Reset: all outputs and internal registers go to 0 and the FSM to HUNT. Reset is async assert and sync release.
- SoT path:
  - sof_r <= start_of_frame_i.
  - valid = sof_r has exactly one bit set; idx = its position.
  - cand = (idx + SLIP_OFFSET) mod FRAME_SIZE.
  - good = valid && cand == slip; bad = !good.
- Data path, per chunk:
  - r1 <= sbits_i; r2 <= r1.
  - sbits_o chunk <= bits [slip+FRAME_SIZE-1 : slip] of {r1 chunk, r2 chunk}, with r2 in the low half.
  - slip=0 gives sbits_i delayed exactly 3 clocks.
  - Output is forced to 0 (registered) while mask_i=1.
- FSM, HUNT:
  - slip <= cand when valid, else slip holds.
  - valid -> VERIFY with stable_cnt=1.
  - If aligned_count_to_ready_i <= 1, a valid frame goes straight to LOCKED.
- FSM, VERIFY:
  - good -> stable_cnt++.
  - When stable_cnt+1 == threshold on a good frame -> LOCKED.
  - bad -> HUNT, stable_cnt=0.
- FSM, LOCKED:
  - slip frozen.
  - good -> miss_cnt=0.
  - bad -> miss_cnt++ and err_cnt++.
  - bad with miss_cnt == miss_tolerance_i -> HUNT, unstable<=1, relock_cnt++, miss_cnt=0.
  - miss_tolerance_i=0 means the first bad frame unlocks.
- sot_is_aligned_o is registered and equals (state==LOCKED) one cycle later.
- mask_i=1:
  - Forces HUNT and zeroes stable_cnt and miss_cnt.
  - Suppresses err/relock increments and unstable setting.
  - Dropping lock because of the mask is not an error.
- clear_i zeroes unstable, err_cnt and relock_cnt. If a set/increment happens in the same cycle, the event wins: unstable=1 and the counter becomes 1.
- Counters saturate at all-ones; no wrap.
- Threshold changes mid-VERIFY take effect on the next comparison. A threshold below the current stable_cnt never locks until the FSM re-enters HUNT.

Test Plan:
- Constant SoT 8'b0000_0100, SLIP_OFFSET=1, threshold=16 -> bitslip_cnt_o=3; sot_is_aligned_o rises 18 clocks after the first SoT edge; sbits_o chunk equals the slip-3 window of the prior and current frames.
- Locked, miss_tolerance_i=2, inject 2 bad SoT frames (8'b0000_0000) then good -> stays locked, err_cnt=2, unstable=0. Inject 3 consecutive bad -> aligned falls, unstable=1, relock_cnt=1.
- SoT jumps from bit 2 to bit 5 while in VERIFY -> back to HUNT; relocks with slip=6 after the threshold count; no error increment.
- Threshold=0 -> LOCKED one cycle after the first valid frame. Two-hot SoT 8'b0001_0001 -> never valid, stays HUNT.
- mask_i asserted while locked -> sbits_o=0, aligned=0, unstable=0, counters unchanged. clear_i coincident with a lock loss -> unstable=1, relock_cnt=1.
- reset_n_i pulsed low mid-LOCKED, asynchronously between clock edges -> all outputs 0 immediately; slip=0 with sbits_o = sbits_i delayed 3 clocks after release; err_cnt saturates at 16'hFFFF under a continuous bad stream.

Source files
------------

// File: rtl/sot_frame_aligner_v2_if.sv
// Bundle of the S-bit data, SoT, control and status signals of one VFAT
// frame aligner. The aligner takes the slave view; the driver of the
// deserialised bits and the monitoring registers takes the master view.
interface sot_frame_aligner_v2_if #(
    parameter int FRAME_SIZE = 8,
    parameter int NUM_CHUNKS = 8,
    parameter int CNT_W      = 12,
    parameter int ERR_W      = 16
);
    localparam int MXSBITS = FRAME_SIZE * NUM_CHUNKS;
    localparam int SLIP_W  = $clog2(FRAME_SIZE);

    logic [MXSBITS-1:0]    sbits_i;
    logic [FRAME_SIZE-1:0] start_of_frame_i;
    logic                  mask_i;
    logic                  clear_i;
    logic [CNT_W-1:0]      aligned_count_to_ready_i;
    logic [3:0]            miss_tolerance_i;

    logic [MXSBITS-1:0]    sbits_o;
    logic [SLIP_W-1:0]     bitslip_cnt_o;
    logic                  sot_is_aligned_o;
    logic                  sot_unstable_o;
    logic [ERR_W-1:0]      sot_err_cnt_o;
    logic [ERR_W-1:0]      sot_relock_cnt_o;

    modport master (
        output sbits_i, start_of_frame_i, mask_i, clear_i,
               aligned_count_to_ready_i, miss_tolerance_i,
        input  sbits_o, bitslip_cnt_o, sot_is_aligned_o, sot_unstable_o,
               sot_err_cnt_o, sot_relock_cnt_o
    );

    modport slave (
        input  sbits_i, start_of_frame_i, mask_i, clear_i,
               aligned_count_to_ready_i, miss_tolerance_i,
        output sbits_o, bitslip_cnt_o, sot_is_aligned_o, sot_unstable_o,
               sot_err_cnt_o, sot_relock_cnt_o
    );
endinterface

// File: rtl/sot_frame_aligner_v2.sv
// Per-VFAT S-bit frame aligner. Decodes the one-hot start-of-frame word into
// a bitslip, qualifies it with a hunt/verify/locked FSM that rides through
// short SoT glitches, and re-windows every frame-sized chunk of S-bits by the
// locked slip. Sticky status and saturating counters feed link monitoring.
// Interface parameters must match the module parameters.
module sot_frame_aligner_v2 #(
    parameter int FRAME_SIZE  = 8,
    parameter int NUM_CHUNKS  = 8,
    parameter int SLIP_OFFSET = 1,
    parameter int CNT_W       = 12,
    parameter int ERR_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset_n_i,
    sot_frame_aligner_v2_if.slave bus
);
    localparam int MXSBITS = FRAME_SIZE * NUM_CHUNKS;
    localparam int SLIP_W  = $clog2(FRAME_SIZE);
    localparam logic [SLIP_W-1:0] SLIP_OFF = SLIP_W'(SLIP_OFFSET % FRAME_SIZE);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Reset release is re-timed to the frame clock; assertion stays async.
    logic [1:0] rst_sync;
    logic       rst_n;

    // Two-flop reset synchroniser: async clear, clocked release.
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // SoT decode
    // ------------------------------------------------------------------
    logic [FRAME_SIZE-1:0] sof_r;
    logic [SLIP_W:0]       sof_ones;
    logic [SLIP_W-1:0]     sof_idx;
    logic [SLIP_W-1:0]     cand;
    logic                  valid;
    logic                  good;
    logic [SLIP_W-1:0]     slip_q;

    // Register the raw SoT word so decode works on a stable frame.
    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            sof_r <= '0;
        end else begin
            sof_r <= bus.start_of_frame_i;
        end
    end

    // Count set bits and locate the (last) set bit; one-hot means valid.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        sof_ones = '0;
        sof_idx  = '0;
        for (int i = 0; i < FRAME_SIZE; i++) begin
            if (sof_r[i]) begin
                sof_ones = sof_ones + (SLIP_W+1)'(1);
                sof_idx  = SLIP_W'(i);
            end
        end
    end

    // Slip width equals log2(FRAME_SIZE), so the add wraps mod FRAME_SIZE.
    assign valid = (sof_ones == (SLIP_W+1)'(1));
    assign cand  = sof_idx + SLIP_OFF;
    assign good  = valid && (cand == slip_q);

    // ------------------------------------------------------------------
    // Data path: two-frame history and per-chunk window
    // ------------------------------------------------------------------
    logic [MXSBITS-1:0]      r1;
    logic [MXSBITS-1:0]      r2;
    logic [MXSBITS-1:0]      win;
    logic [2*FRAME_SIZE-1:0] pair;
    logic [MXSBITS-1:0]      sbits_q;

    // Select FRAME_SIZE bits at the slip from {newer, older} frame per chunk.
    always_comb begin
        win  = '0;
        pair = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            pair = {r1[c*FRAME_SIZE +: FRAME_SIZE], r2[c*FRAME_SIZE +: FRAME_SIZE]};
            win[c*FRAME_SIZE +: FRAME_SIZE] = pair[slip_q +: FRAME_SIZE];
        end
    end

    // Frame history and registered, maskable aligned output.
    always_ff @(posedge clock or negedge rst_n) begin
        // NOTE: the data pipeline is reset too, so sbits_o is a defined zero
        // right after reset instead of stale deserialiser contents.
        if (!rst_n) begin
            r1      <= '0;
            r2      <= '0;
            sbits_q <= '0;
        end else begin
            r1      <= bus.sbits_i;
            r2      <= r1;
            sbits_q <= bus.mask_i ? '0 : win;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [SLIP_W-1:0] slip_d;
    logic [CNT_W-1:0]  stable_q, stable_d;
    logic [CNT_W:0]    stable_inc;
    logic [3:0]        miss_q, miss_d;
    logic              err_inc;
    logic              lock_lost;

    assign stable_inc = {1'b0, stable_q} + (CNT_W+1)'(1);

    // State, slip and counters of the lock FSM.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slip_q   <= '0;
            stable_q <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            slip_q   <= slip_d;
            stable_q <= stable_d;
            miss_q   <= miss_d;
        end
    end

    // Next state plus error/lock-loss events; mask overrides everything.
    always_comb begin
        state_d   = state_q;
        slip_d    = slip_q;
        stable_d  = stable_q;
        miss_d    = miss_q;
        err_inc   = 1'b0;
        lock_lost = 1'b0;
        if (bus.mask_i) begin
            state_d  = HUNT;
            stable_d = '0;
            miss_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (valid) begin
                        slip_d   = cand;
                        stable_d = CNT_W'(1);
                        state_d  = (bus.aligned_count_to_ready_i <= CNT_W'(1)) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (good) begin
                        // Equality only: a threshold already passed never locks.
                        if (stable_inc == {1'b0, bus.aligned_count_to_ready_i}) begin
                            state_d = LOCKED;
                        end
                        if (stable_q != '1) begin
                            stable_d = stable_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_d  = HUNT;
                        stable_d = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        if (miss_q == bus.miss_tolerance_i) begin
                            state_d   = HUNT;
                            stable_d  = '0;
                            miss_d    = '0;
                            lock_lost = 1'b1;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status: lock flag, sticky instability, saturating counters
    // ------------------------------------------------------------------
    logic             aligned_q;
    logic             unstable_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] relock_q;

    // An event in the same cycle as clear wins over the clear.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            aligned_q  <= 1'b0;
            unstable_q <= 1'b0;
            err_q      <= '0;
            relock_q   <= '0;
        end else begin
            aligned_q <= (state_q == LOCKED);

            if (lock_lost) begin
                unstable_q <= 1'b1;
            end else if (bus.clear_i) begin
                unstable_q <= 1'b0;
            end

            if (bus.clear_i) begin
                err_q <= err_inc ? ERR_W'(1) : '0;
            end else if (err_inc && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end

            if (bus.clear_i) begin
                relock_q <= lock_lost ? ERR_W'(1) : '0;
            end else if (lock_lost && (relock_q != '1)) begin
                relock_q <= relock_q + ERR_W'(1);
            end
        end
    end

    assign bus.sbits_o          = sbits_q;
    assign bus.bitslip_cnt_o    = slip_q;
    assign bus.sot_is_aligned_o = aligned_q;
    assign bus.sot_unstable_o   = unstable_q;
    assign bus.sot_err_cnt_o    = err_q;
    assign bus.sot_relock_cnt_o = relock_q;
endmodule

// File: tb/tb_sot_frame_aligner_v2.sv
// Directed bench for sot_frame_aligner_v2 (FRAME_SIZE=8, NUM_CHUNKS=8,
// SLIP_OFFSET=1). Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, so "step(k)" means k clock edges later.
module tb_sot_frame_aligner_v2;
    localparam int F     = 8;
    localparam int N     = 8;
    localparam int CNT_W = 12;
    localparam int ERR_W = 16;

    logic clock = 1'b0;
    logic reset_n_i;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clock = ~clock;

    sot_frame_aligner_v2_if #(
        .FRAME_SIZE(F), .NUM_CHUNKS(N), .CNT_W(CNT_W), .ERR_W(ERR_W)
    ) bus_if ();

    sot_frame_aligner_v2 #(
        .FRAME_SIZE(F), .NUM_CHUNKS(N), .SLIP_OFFSET(1), .CNT_W(CNT_W), .ERR_W(ERR_W)
    ) dut (
        .clock     (clock),
        .reset_n_i (reset_n_i),
        .bus       (bus_if)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sbits"},    bus_if.sbits_o,          64'h0);
        check({tag, "_slip"},     bus_if.bitslip_cnt_o,    64'h0);
        check({tag, "_aligned"},  bus_if.sot_is_aligned_o, 64'h0);
        check({tag, "_unstable"}, bus_if.sot_unstable_o,   64'h0);
        check({tag, "_err"},      bus_if.sot_err_cnt_o,    64'h0);
        check({tag, "_relock"},   bus_if.sot_relock_cnt_o, 64'h0);
    endtask

    logic [63:0] vec [0:5];

    initial begin
        vec[0] = 64'h1111_2222_3333_4444;
        vec[1] = 64'hA5A5_5A5A_0F0F_F0F0;
        vec[2] = 64'h0123_4567_89AB_CDEF;
        vec[3] = 64'hDEAD_BEEF_CAFE_F00D;
        vec[4] = 64'h8000_0000_0000_0001;
        vec[5] = 64'h7E7E_8181_3C3C_C3C3;

        reset_n_i                       = 1'b0;
        bus_if.sbits_i                  = '0;
        bus_if.start_of_frame_i         = '0;
        bus_if.mask_i                   = 1'b0;
        bus_if.clear_i                  = 1'b0;
        bus_if.aligned_count_to_ready_i = 12'd16;
        bus_if.miss_tolerance_i         = 4'd2;
        step(2);
        check_all_zero("reset");
        reset_n_i = 1'b1;
        step(4);

        // Lock on SoT bit 2 -> slip 3, 16 good frames, aligned 18 edges later.
        bus_if.start_of_frame_i = 8'b0000_0100;
        step(17);
        check("lock_not_early", bus_if.sot_is_aligned_o, 64'h0);
        step(1);
        check("lock_at_18", bus_if.sot_is_aligned_o, 64'h1);
        check("slip_3", bus_if.bitslip_cnt_o, 64'h3);

        // Slip 3 window: chunk = {newer[2:0], older[7:3]}.
        bus_if.sbits_i = 64'h0123_4567_89AB_CDEF;
        step(1);
        bus_if.sbits_i = 64'hFEDC_BA98_7654_3210;
        step(2);
        check("window_slip3", bus_if.sbits_o, 64'hC084_480C_D195_591D);

        // Two bad frames are tolerated with miss_tolerance 2.
        bus_if.start_of_frame_i = 8'h00;
        step(2);
        bus_if.start_of_frame_i = 8'b0000_0100;
        step(4);
        check("tol_aligned", bus_if.sot_is_aligned_o, 64'h1);
        check("tol_err2", bus_if.sot_err_cnt_o, 64'd2);
        check("tol_unstable0", bus_if.sot_unstable_o, 64'h0);

        // Three bad frames unlock.
        bus_if.start_of_frame_i = 8'h00;
        step(3);
        bus_if.start_of_frame_i = 8'b0000_0100;
        step(2);
        check("unlock_aligned0", bus_if.sot_is_aligned_o, 64'h0);
        check("unlock_unstable1", bus_if.sot_unstable_o, 64'h1);
        check("unlock_relock1", bus_if.sot_relock_cnt_o, 64'd1);
        check("unlock_err5", bus_if.sot_err_cnt_o, 64'd5);

        // SoT jumps to bit 5 during VERIFY -> rehunt, relock at slip 6.
        bus_if.start_of_frame_i = 8'b0010_0000;
        step(18);
        check("jump_not_early", bus_if.sot_is_aligned_o, 64'h0);
        check("jump_slip6", bus_if.bitslip_cnt_o, 64'h6);
        step(1);
        check("jump_locked", bus_if.sot_is_aligned_o, 64'h1);
        check("jump_err_same", bus_if.sot_err_cnt_o, 64'd5);

        // Clear, then one counted error while locked.
        bus_if.clear_i = 1'b1;
        step(1);
        bus_if.clear_i = 1'b0;
        check("clear_unstable", bus_if.sot_unstable_o, 64'h0);
        check("clear_err", bus_if.sot_err_cnt_o, 64'h0);
        check("clear_relock", bus_if.sot_relock_cnt_o, 64'h0);
        bus_if.start_of_frame_i = 8'h00;
        step(1);
        bus_if.start_of_frame_i = 8'b0010_0000;
        step(3);
        check("pre_mask_err1", bus_if.sot_err_cnt_o, 64'd1);
        check("pre_mask_aligned", bus_if.sot_is_aligned_o, 64'h1);

        // Mask while locked, with a bad frame arriving under the mask.
        bus_if.sbits_i          = vec[3];
        bus_if.start_of_frame_i = 8'h00;
        step(1);
        bus_if.mask_i = 1'b1;
        step(3);
        check("mask_sbits0", bus_if.sbits_o, 64'h0);
        check("mask_aligned0", bus_if.sot_is_aligned_o, 64'h0);
        check("mask_unstable0", bus_if.sot_unstable_o, 64'h0);
        check("mask_err_same", bus_if.sot_err_cnt_o, 64'd1);
        check("mask_relock_same", bus_if.sot_relock_cnt_o, 64'h0);

        // Two-hot SoT is never valid; threshold 0 locks on first valid frame.
        bus_if.mask_i                   = 1'b0;
        bus_if.aligned_count_to_ready_i = 12'd0;
        bus_if.start_of_frame_i         = 8'b0001_0001;
        step(10);
        check("twohot_hunt", bus_if.sot_is_aligned_o, 64'h0);
        check("twohot_slip_hold", bus_if.bitslip_cnt_o, 64'h6);
        bus_if.start_of_frame_i = 8'b0000_0001;
        step(2);
        check("thr0_not_yet", bus_if.sot_is_aligned_o, 64'h0);
        step(1);
        check("thr0_locked", bus_if.sot_is_aligned_o, 64'h1);
        check("thr0_slip1", bus_if.bitslip_cnt_o, 64'h1);

        // Clear coincident with a lock loss (tolerance 0): event wins.
        bus_if.miss_tolerance_i = 4'd0;
        bus_if.start_of_frame_i = 8'h00;
        step(1);
        bus_if.clear_i = 1'b1;
        step(1);
        bus_if.clear_i = 1'b0;
        check("clr_evt_unstable", bus_if.sot_unstable_o, 64'h1);
        check("clr_evt_relock", bus_if.sot_relock_cnt_o, 64'd1);
        check("clr_evt_err", bus_if.sot_err_cnt_o, 64'd1);
        step(1);
        check("clr_evt_aligned0", bus_if.sot_is_aligned_o, 64'h0);

        // Relock, then assert reset between clock edges.
        bus_if.miss_tolerance_i = 4'd2;
        bus_if.start_of_frame_i = 8'b0000_0001;
        bus_if.sbits_i          = vec[1];
        step(4);
        check("prereset_locked", bus_if.sot_is_aligned_o, 64'h1);
        #3;
        reset_n_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus_if.start_of_frame_i = 8'h00;
        step(2);
        reset_n_i = 1'b1;
        step(4);
        check("post_reset_slip0", bus_if.bitslip_cnt_o, 64'h0);
        for (int k = 0; k < 6; k++) begin
            bus_if.sbits_i = vec[k];
            step(1);
            if (k >= 2) begin
                check($sformatf("delay3_%0d", k), bus_if.sbits_o, vec[k-2]);
            end
        end

        // Saturation: threshold 0, tolerance 15 -> 16 errors per 17 frames.
        bus_if.aligned_count_to_ready_i = 12'd0;
        bus_if.miss_tolerance_i         = 4'd15;
        for (int r = 0; r < 4100; r++) begin
            bus_if.start_of_frame_i = 8'b0000_0001;
            step(1);
            bus_if.start_of_frame_i = 8'h00;
            step(16);
        end
        step(3);
        check("err_saturated", bus_if.sot_err_cnt_o, 64'hFFFF);
        check("relock_4100", bus_if.sot_relock_cnt_o, 64'd4100);
        check("sat_unstable", bus_if.sot_unstable_o, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
